// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file's single write port.
// Two sources (0 = ALU, 1 = load unit) each feed a one-entry holding buffer.
// A round-robin arbiter picks one full buffer per cycle and drives a registered
// write onto the register file. A pending-write scoreboard tracks destinations
// that decode has claimed but that have not yet been written back.
module regfile_wb_arbiter #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NREGS      = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s0_valid,
  input  logic [ADDR_WIDTH-1:0] s0_addr,
  input  logic [DATA_WIDTH-1:0] s0_data,
  output logic                  s0_ready,
  input  logic                  s1_valid,
  input  logic [ADDR_WIDTH-1:0] s1_addr,
  input  logic [DATA_WIDTH-1:0] s1_data,
  output logic                  s1_ready,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic [DATA_WIDTH-1:0] rf_data,
  input  logic                  claim_valid,
  input  logic [ADDR_WIDTH-1:0] claim_addr,
  input  logic [ADDR_WIDTH-1:0] chk_addr_a,
  input  logic [ADDR_WIDTH-1:0] chk_addr_b,
  output logic                  busy_a,
  output logic                  busy_b
);

  logic                  full0_q, full1_q;
  logic [ADDR_WIDTH-1:0] addr0_q, addr1_q;
  logic [DATA_WIDTH-1:0] data0_q, data1_q;
  logic                  rr_q;
  logic [NREGS-1:0]      pending_q, pending_d;
  logic                  grant0, grant1;

  // Round-robin grant: a lone full buffer always wins, rr breaks ties.
  always_comb begin
    grant0 = full0_q && (!full1_q || !rr_q);
    grant1 = full1_q && (!full0_q || rr_q);
  end

  // A buffer being drained this cycle may reload on the same edge.
  always_comb begin
    s0_ready = reset && (!full0_q || grant0);
    s1_ready = reset && (!full1_q || grant1);
  end

  // Source 0 holding buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full0_q <= 1'b0;
      addr0_q <= '0;
      data0_q <= '0;
    end else if (s0_valid && s0_ready) begin
      full0_q <= 1'b1;
      addr0_q <= s0_addr;
      data0_q <= s0_data;
    end else if (grant0) begin
      full0_q <= 1'b0;
    end
  end

  // Source 1 holding buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full1_q <= 1'b0;
      addr1_q <= '0;
      data1_q <= '0;
    end else if (s1_valid && s1_ready) begin
      full1_q <= 1'b1;
      addr1_q <= s1_addr;
      data1_q <= s1_data;
    end else if (grant1) begin
      full1_q <= 1'b0;
    end
  end

  // Round-robin pointer points away from the most recently granted source.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q <= 1'b0;
    end else if (grant0) begin
      rr_q <= 1'b1;
    end else if (grant1) begin
      rr_q <= 1'b0;
    end
  end

  // Registered write stage; r0 writes are arbitrated but never enable the port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we   <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
    end else if (grant0) begin
      rf_we   <= (addr0_q != '0);
      rf_addr <= addr0_q;
      rf_data <= data0_q;
    end else if (grant1) begin
      rf_we   <= (addr1_q != '0);
      rf_addr <= addr1_q;
      rf_data <= data1_q;
    end else begin
      rf_we <= 1'b0;
    end
  end

  // Scoreboard next state: clears first, so a same-edge claim (newer producer) wins.
  always_comb begin
    pending_d = pending_q;
    if (grant0 && (addr0_q != '0)) pending_d[addr0_q] = 1'b0;
    if (grant1 && (addr1_q != '0)) pending_d[addr1_q] = 1'b0;
    if (claim_valid && (claim_addr != '0)) pending_d[claim_addr] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Busy lookups for decode's two source operands.
  always_comb begin
    busy_a = pending_q[chk_addr_a];
    busy_b = pending_q[chk_addr_b];
  end

endmodule
